// File: rtl/out_buf_drain.sv
// Output-buffer drain: sweeps the tile read address, captures the 1-cycle-late read
// data into a small FWFT skid FIFO and streams it out with valid/ready and end-of-tile.
module out_buf_drain #(
   parameter  int OUT_DATA_WIDTH  = 16,
   parameter  int OC_UNROLL_WIDTH = 4,
   parameter  int TILE_SIZE_WIDTH = 5,
   parameter  int FIFO_DEPTH      = 2,
   localparam int OC_UNROLL_NUM   = 2**OC_UNROLL_WIDTH,
   localparam int OUT_ADDR_WIDTH  = 2*TILE_SIZE_WIDTH,
   localparam int DATA_WIDTH      = OUT_DATA_WIDTH*OC_UNROLL_NUM
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tile_done,
   input  logic [TILE_SIZE_WIDTH-1:0] oh_last,
   input  logic [TILE_SIZE_WIDTH-1:0] ow_last,
   output logic [OUT_ADDR_WIDTH-1:0]  after_check_addr,
   input  logic [DATA_WIDTH-1:0]      check_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [DATA_WIDTH-1:0]      m_data,
   output logic [OUT_ADDR_WIDTH-1:0]  m_addr,
   output logic                       m_last,
   output logic                       drain_done
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

   state_t                      state_q, state_d;
   logic                        tile_done_q;
   logic [TILE_SIZE_WIDTH-1:0]  oh, ow, oh_last_q, ow_last_q;
   logic [OUT_ADDR_WIDTH-1:0]   addr_hold, inflight_addr;
   logic                        inflight, inflight_last;

   logic [DATA_WIDTH-1:0]       fifo_data [FIFO_DEPTH];
   logic [OUT_ADDR_WIDTH-1:0]   fifo_addr [FIFO_DEPTH];
   logic                        fifo_last [FIFO_DEPTH];
   logic [PW-1:0]               rd_ptr, wr_ptr;
   logic [CW-1:0]               count;

   logic                        start, issue, is_last_rd, push, pop;
   logic [CW:0]                 occ;

   assign start      = tile_done & ~tile_done_q;
   assign is_last_rd = (oh == oh_last_q) && (ow == ow_last_q);
   assign push       = inflight;
   assign pop        = m_valid & m_ready;

   // Occupancy counts the word leaving this cycle as gone, so a read can issue every
   // cycle under full throughput; the pushed word still always finds a free slot.
   assign occ = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight};

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         IDLE:  if (start) state_d = READ;
         READ: begin
            if (occ < (CW+1)'(FIFO_DEPTH)) begin
               issue = 1'b1;
               if (is_last_rd) state_d = FLUSH;
            end
         end
         FLUSH: if (pop && m_last) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign drain_done       = (state_q == DONE);
   assign after_check_addr = issue ? {oh, ow} : addr_hold;
   assign m_valid          = (count != '0);
   assign m_data           = m_valid ? fifo_data[rd_ptr] : '0;
   assign m_addr           = m_valid ? fifo_addr[rd_ptr] : '0;
   assign m_last           = m_valid ? fifo_last[rd_ptr] : 1'b0;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         tile_done_q   <= 1'b0;
         oh            <= '0;
         ow            <= '0;
         oh_last_q     <= '0;
         ow_last_q     <= '0;
         addr_hold     <= '0;
         inflight      <= 1'b0;
         inflight_addr <= '0;
         inflight_last <= 1'b0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
      end else begin
         state_q     <= state_d;
         tile_done_q <= tile_done;
         inflight    <= issue;
         if (state_q == IDLE && start) begin
            oh_last_q <= oh_last;
            ow_last_q <= ow_last;
            oh        <= '0;
            ow        <= '0;
         end
         if (issue) begin
            addr_hold     <= {oh, ow};
            inflight_addr <= {oh, ow};
            inflight_last <= is_last_rd;
            if (ow == ow_last_q) begin
               ow <= '0;
               oh <= oh + 1'b1;
            end else begin
               ow <= ow + 1'b1;
            end
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: FIFO storage is not reset; outputs are masked while empty, so stale
   // entries are never visible.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= check_data;
         fifo_addr[wr_ptr] <= inflight_addr;
         fifo_last[wr_ptr] <= inflight_last;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) assert (!(push && count == CW'(FIFO_DEPTH)));
   end

endmodule
